// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the register bank: round-robin between ALU writeback (A)
// and memory load (M), plus a clear-all sequencer. All outputs are registered.
module reg_write_arbiter #(
  parameter int NREG = 4,
  parameter int W    = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            Clock,
  input  logic            Clr_n,
  input  logic            A_req,
  input  logic [AW-1:0]   A_addr,
  input  logic [W-1:0]    A_data,
  output logic            A_gnt,
  input  logic            M_req,
  input  logic [AW-1:0]   M_addr,
  input  logic [W-1:0]    M_data,
  output logic            M_gnt,
  input  logic            ClrAll_req,
  output logic            ClrAll_done,
  output logic            Busy,
  output logic [W-1:0]    RegH,
  output logic [NREG-1:0] RegEnable,
  output logic [NREG-1:0] RegClr
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic          LAST_A   = 1'b0;
  localparam logic          LAST_M   = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t          state, state_nx;
  logic [AW-1:0]   idx, idx_nx, idx_inc;
  logic            last, last_nx;
  logic [NREG-1:0] en_nx, clr_nx;
  logic [W-1:0]    h_nx;
  logic            a_gnt_nx, m_gnt_nx, busy_nx, done_nx;
  logic            a_elig, m_elig, pick_a, pick_m;

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] i);
    logic [NREG-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // A requester whose grant pulse is showing now is not eligible again this edge
  assign a_elig  = A_req && !A_gnt;
  assign m_elig  = M_req && !M_gnt;
  assign pick_a  = a_elig && (!m_elig || (last == LAST_M));
  assign pick_m  = m_elig && !pick_a;
  assign idx_inc = idx + 1'b1;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    last_nx  = last;
    en_nx    = '0;
    clr_nx   = '0;
    h_nx     = RegH;
    a_gnt_nx = 1'b0;
    m_gnt_nx = 1'b0;
    busy_nx  = Busy;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ClrAll_req) begin
          state_nx = CLEAR;
          idx_nx   = '0;
          en_nx    = onehot('0);
          clr_nx   = onehot('0);
          busy_nx  = 1'b1;
        end else if (pick_a) begin
          a_gnt_nx = 1'b1;
          en_nx    = onehot(A_addr);
          h_nx     = A_data;
          last_nx  = LAST_A;
        end else if (pick_m) begin
          m_gnt_nx = 1'b1;
          en_nx    = onehot(M_addr);
          h_nx     = M_data;
          last_nx  = LAST_M;
        end
      end
      CLEAR: begin
        if (idx != LAST_IDX) begin
          idx_nx  = idx_inc;
          en_nx   = onehot(idx_inc);
          clr_nx  = onehot(idx_inc);
          done_nx = (idx_inc == LAST_IDX);
        end else begin
          state_nx = IDLE;
          idx_nx   = '0;
          busy_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clr_n) begin
    if (!Clr_n) begin
      state       <= IDLE;
      idx         <= '0;
      last        <= LAST_M;
      RegEnable   <= '0;
      RegClr      <= '0;
      RegH        <= '0;
      A_gnt       <= 1'b0;
      M_gnt       <= 1'b0;
      Busy        <= 1'b0;
      ClrAll_done <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      last        <= last_nx;
      RegEnable   <= en_nx;
      RegClr      <= clr_nx;
      RegH        <= h_nx;
      A_gnt       <= a_gnt_nx;
      M_gnt       <= m_gnt_nx;
      Busy        <= busy_nx;
      ClrAll_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural 4x8-bit register bank
// on its strobes; hand-computed expectations checked with immediate assertions.
module tb_reg_write_arbiter;

  logic       Clock = 1'b0;
  logic       Clr_n;
  logic       A_req, M_req, ClrAll_req;
  logic [1:0] A_addr, M_addr;
  logic [7:0] A_data, M_data;
  logic       A_gnt, M_gnt, ClrAll_done, Busy;
  logic [7:0] RegH;
  logic [3:0] RegEnable, RegClr;

  logic [7:0] bank [4];
  int total = 0;
  int bad   = 0;

  reg_write_arbiter #(.NREG(4), .W(8)) dut (
    .Clock(Clock), .Clr_n(Clr_n),
    .A_req(A_req), .A_addr(A_addr), .A_data(A_data), .A_gnt(A_gnt),
    .M_req(M_req), .M_addr(M_addr), .M_data(M_data), .M_gnt(M_gnt),
    .ClrAll_req(ClrAll_req), .ClrAll_done(ClrAll_done), .Busy(Busy),
    .RegH(RegH), .RegEnable(RegEnable), .RegClr(RegClr)
  );

  always #5 Clock = ~Clock;

  // Register bank model: Clr wins over load, both gated by Enable
  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++)
      if (RegEnable[i]) bank[i] <= RegClr[i] ? 8'h00 : RegH;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_en"},   RegEnable, 0);
    chk({pfx, "_clr"},  RegClr, 0);
    chk({pfx, "_h"},    RegH, 0);
    chk({pfx, "_agnt"}, A_gnt, 0);
    chk({pfx, "_mgnt"}, M_gnt, 0);
    chk({pfx, "_busy"}, Busy, 0);
    chk({pfx, "_done"}, ClrAll_done, 0);
  endtask

  task automatic write_a(input logic [1:0] addr, input logic [7:0] data);
    A_req = 1'b1; A_addr = addr; A_data = data;
    tick();
    chk("pre_agnt", A_gnt, 1);
    A_req = 1'b0;
    tick();
  endtask

  logic       exp_a;
  logic [3:0] exp_en;
  logic [7:0] exp_h;
  logic       exp_g;

  initial begin
    Clr_n = 1'b0; A_req = 0; M_req = 0; ClrAll_req = 0;
    A_addr = 0; M_addr = 0; A_data = 0; M_data = 0;
    repeat (2) @(posedge Clock);
    #1;
    chk_all_zero("rst");
    Clr_n = 1'b1;

    // tie after reset: A first, then M
    A_req = 1; A_addr = 2'd1; A_data = 8'h11;
    M_req = 1; M_addr = 2'd3; M_data = 8'h33;
    tick();
    chk("tie_agnt", A_gnt, 1);
    chk("tie_mgnt", M_gnt, 0);
    chk("tie_en", RegEnable, 4'b0010);
    chk("tie_h", RegH, 8'h11);
    A_req = 0;
    tick();
    chk("tie2_mgnt", M_gnt, 1);
    chk("tie2_agnt", A_gnt, 0);
    chk("tie2_en", RegEnable, 4'b1000);
    chk("tie2_h", RegH, 8'h33);
    M_req = 0;
    tick();
    chk("idle_en", RegEnable, 0);
    chk("idle_hhold", RegH, 8'h33);
    chk("tie_r1", bank[1], 8'h11);
    chk("tie_r3", bank[3], 8'h33);

    // single write
    A_req = 1; A_addr = 2'd2; A_data = 8'h5A;
    tick();
    chk("single_agnt", A_gnt, 1);
    chk("single_en", RegEnable, 4'b0100);
    chk("single_h", RegH, 8'h5A);
    chk("single_clr", RegClr, 0);
    A_req = 0;
    tick();
    chk("single_agnt_off", A_gnt, 0);
    chk("single_en_off", RegEnable, 0);
    chk("single_r2", bank[2], 8'h5A);

    // contention: last was A, so M leads
    exp_a = 1'b0;
    A_req = 1; A_addr = 2'd0; A_data = 8'hA0;
    M_req = 1; M_addr = 2'd1; M_data = 8'hB0;
    for (int n = 0; n < 6; n++) begin
      exp_h  = exp_a ? A_data : M_data;
      exp_en = exp_a ? 4'b0001 : 4'b0010;
      tick();
      chk("con_agnt", A_gnt, exp_a);
      chk("con_mgnt", M_gnt, !exp_a);
      chk("con_en", RegEnable, exp_en);
      chk("con_h", RegH, exp_h);
      if (exp_a) A_data = A_data + 8'd1;
      else       M_data = M_data + 8'd1;
      exp_a = !exp_a;
    end
    A_req = 0; M_req = 0;
    tick();
    chk("con_end_agnt", A_gnt, 0);
    chk("con_end_mgnt", M_gnt, 0);
    chk("con_r0", bank[0], 8'hA2);
    chk("con_r1", bank[1], 8'hB2);

    // solo M held high: grant every other cycle
    M_req = 1; M_addr = 2'd0; M_data = 8'hC0;
    for (int n = 0; n < 6; n++) begin
      exp_g  = (n % 2 == 0);
      exp_en = exp_g ? (4'b0001 << M_addr) : 4'b0000;
      tick();
      chk("solo_mgnt", M_gnt, exp_g);
      chk("solo_agnt", A_gnt, 0);
      chk("solo_en", RegEnable, exp_en);
      if (exp_g) begin
        M_addr = M_addr + 2'd1;
        M_data = 8'hC0 + {6'd0, M_addr};
      end
    end
    M_req = 0;
    tick();
    chk("solo_r0", bank[0], 8'hC0);
    chk("solo_r1", bank[1], 8'hC1);
    chk("solo_r2", bank[2], 8'hC2);

    // clear-all with a pending write
    for (int i = 0; i < 4; i++) write_a(i[1:0], 8'hFF);
    ClrAll_req = 1;
    A_req = 1; A_addr = 2'd2; A_data = 8'h77;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("clr_clr", RegClr, 4'b0001 << n);
      chk("clr_en", RegEnable, 4'b0001 << n);
      chk("clr_busy", Busy, 1);
      chk("clr_done", ClrAll_done, n == 3);
      chk("clr_agnt", A_gnt, 0);
    end
    ClrAll_req = 0;
    tick();
    chk("clr_end_busy", Busy, 0);
    chk("clr_end_en", RegEnable, 0);
    chk("clr_end_done", ClrAll_done, 0);
    chk("clr_end_agnt", A_gnt, 0);
    for (int i = 0; i < 4; i++) chk("clr_reg", bank[i], 8'h00);
    tick();
    chk("post_clr_agnt", A_gnt, 1);
    chk("post_clr_en", RegEnable, 4'b0100);
    chk("post_clr_h", RegH, 8'h77);
    A_req = 0;
    tick();
    chk("post_clr_r2", bank[2], 8'h77);

    // reset in the middle of a clear sequence
    write_a(2'd2, 8'hFF);
    write_a(2'd3, 8'hFF);
    ClrAll_req = 1;
    tick();
    tick();
    chk("mr_clr", RegClr, 4'b0010);
    #2 Clr_n = 1'b0;
    #1;
    chk_all_zero("mr");
    ClrAll_req = 0;
    #2 Clr_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("mr_done", ClrAll_done, 0);
      chk("mr_busy", Busy, 0);
      chk("mr_en", RegEnable, 0);
    end
    chk("mr_r2", bank[2], 8'hFF);
    chk("mr_r3", bank[3], 8'hFF);

    // reset restores A priority on a tie
    A_req = 1; A_addr = 2'd0; A_data = 8'h01;
    M_req = 1; M_addr = 2'd1; M_data = 8'h02;
    tick();
    chk("mr_tie_agnt", A_gnt, 1);
    chk("mr_tie_mgnt", M_gnt, 0);
    A_req = 0; M_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
